// File: rtl/z80_bus_model_if.sv
// CPU-side Z80 bus: address, data and active-low strobes toward the memory/IO model,
// plus read data and the wait request back toward the CPU.
interface z80_bus_model_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] A;
  logic [7:0]        dout;
  logic [7:0]        di;
  logic              m1_n, mreq_n, iorq_n, rd_n, wr_n;
  logic              wait_n;

  modport master (output A, dout, m1_n, mreq_n, iorq_n, rd_n, wr_n,
                  input  di, wait_n);
  modport slave  (input  A, dout, m1_n, mreq_n, iorq_n, rd_n, wr_n,
                  output di, wait_n);
endinterface

// File: rtl/z80_bus_model.sv
// Z80 bus slave: byte memory and I/O space with per-space wait states,
// exactly-once write commit and a FIFO log of committed writes.
module z80_bus_model #(
  parameter int ADDR_W    = 16,
  parameter int IO_AW     = 8,
  parameter int MEM_WAIT  = 0,
  parameter int IO_WAIT   = 1,
  parameter int LOG_DEPTH = 8,
  localparam int CW = $clog2(LOG_DEPTH + 1),
  localparam int PW = $clog2(LOG_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  z80_bus_model_if.slave    bus,
  input  logic              log_pop,
  output logic              log_valid,
  output logic [ADDR_W-1:0] log_addr,
  output logic [7:0]        log_data,
  output logic              log_is_io,
  output logic [CW-1:0]     log_count,
  output logic              log_overflow
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  logic [7:0] mem [2**ADDR_W];
  logic [7:0] io  [2**IO_AW];

  logic [ADDR_W-1:0] log_a [LOG_DEPTH];
  logic [7:0]        log_d [LOG_DEPTH];
  logic              log_i [LOG_DEPTH];

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          acc_io_q, acc_io_d;
  logic [7:0]    mem_rd_q, mem_rd_d, io_rd_q, io_rd_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic             mem_acc, io_acc, int_ack, bus_idle, commit, we;
  logic             full, pop_ok, push_ok;
  logic [3:0]       wcnt;
  logic [IO_AW-1:0] a_io;

  assign a_io     = bus.A[IO_AW-1:0];
  assign mem_acc  = !bus.mreq_n && (!bus.rd_n || !bus.wr_n);
  assign io_acc   = !bus.iorq_n && bus.m1_n && (!bus.rd_n || !bus.wr_n);
  assign int_ack  = !bus.iorq_n && !bus.m1_n;
  assign bus_idle = bus.mreq_n && bus.iorq_n && bus.rd_n && bus.wr_n;
  assign wcnt     = mem_acc ? 4'(MEM_WAIT) : 4'(IO_WAIT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_io_d = acc_io_q;
    commit   = 1'b0;
    case (state_q)
      IDLE: if (mem_acc || io_acc) begin
        acc_io_d = !mem_acc;
        cnt_d    = wcnt;
        if (wcnt != 4'd0) state_d = WAIT;
        else begin
          state_d = DONE;
          commit  = !bus.wr_n;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          commit  = !bus.wr_n;
        end
      end
      DONE:    if (bus_idle) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gate with reset so an access aborted by reset never lands in memory.
  assign we         = commit && !reset;
  assign bus.wait_n = (state_q != WAIT);
  assign bus.di     = int_ack ? 8'hFF : (!bus.iorq_n ? io_rd_q : mem_rd_q);

  assign full    = (count_q == CW'(LOG_DEPTH));
  assign pop_ok  = log_pop && (count_q != '0);
  assign push_ok = we && (!full || pop_ok);

  always_comb begin
    mem_rd_d = mem[bus.A];
    io_rd_d  = io[a_io];
    wptr_d   = wptr_q + PW'(push_ok);
    rptr_d   = rptr_q + PW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    ovf_d    = ovf_q || (we && full && !pop_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_io_q <= 1'b0;
      mem_rd_q <= 8'hFF;
      io_rd_q  <= 8'hFF;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_io_q <= acc_io_d;
      mem_rd_q <= mem_rd_d;
      io_rd_q  <= io_rd_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is never reset so the bench can preload it hierarchically.
  always_ff @(posedge clk) begin
    if (we && !acc_io_d) mem[bus.A] <= bus.dout;
    if (we && acc_io_d)  io[a_io]   <= bus.dout;
    if (push_ok) begin
      log_a[wptr_q] <= acc_io_d ? ADDR_W'(a_io) : bus.A;
      log_d[wptr_q] <= bus.dout;
      log_i[wptr_q] <= acc_io_d;
    end
  end

  assign log_valid    = (count_q != '0);
  assign log_addr     = log_a[rptr_q];
  assign log_data     = log_d[rptr_q];
  assign log_is_io    = log_i[rptr_q];
  assign log_count    = count_q;
  assign log_overflow = ovf_q;
endmodule

// File: tb/tb_z80_bus_model.sv
// Directed bench: a default-parameter instance and a MEM_WAIT=3/IO_WAIT=2/LOG_DEPTH=4
// instance share one CPU bus; committed writes are checked against a log scoreboard.
module tb_z80_bus_model;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] a;
  logic [7:0]  d;
  logic m1n, mreqn, iorqn, rdn, wrn;
  logic pop0, pop1;

  z80_bus_model_if #(.ADDR_W(16)) b0 ();
  z80_bus_model_if #(.ADDR_W(16)) b1 ();
  assign b0.A = a;      assign b1.A = a;
  assign b0.dout = d;   assign b1.dout = d;
  assign b0.m1_n = m1n; assign b1.m1_n = m1n;
  assign b0.mreq_n = mreqn; assign b1.mreq_n = mreqn;
  assign b0.iorq_n = iorqn; assign b1.iorq_n = iorqn;
  assign b0.rd_n = rdn; assign b1.rd_n = rdn;
  assign b0.wr_n = wrn; assign b1.wr_n = wrn;

  logic        lv0, lio0, ovf0, lv1, lio1, ovf1;
  logic [15:0] la0, la1;
  logic [7:0]  ld0, ld1;
  logic [3:0]  lc0;
  logic [2:0]  lc1;

  z80_bus_model u_def (
    .clk(clk), .reset(rst), .bus(b0), .log_pop(pop0),
    .log_valid(lv0), .log_addr(la0), .log_data(ld0), .log_is_io(lio0),
    .log_count(lc0), .log_overflow(ovf0));

  z80_bus_model #(.MEM_WAIT(3), .IO_WAIT(2), .LOG_DEPTH(4)) u_cfg (
    .clk(clk), .reset(rst), .bus(b1), .log_pop(pop1),
    .log_valid(lv1), .log_addr(la1), .log_data(ld1), .log_is_io(lio1),
    .log_count(lc1), .log_overflow(ovf1));

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        io;
  } ent_t;
  ent_t exp_q[$];

  int errs = 0;
  int checks = 0;
  logic mdl_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 fetch, 1 mem read, 2 mem write, 3 io read, 4 io write.
  // pop_at >= 0 raises log_pop on the cfg instance after that many wait samples.
  task automatic bus_cycle(input int kind, input logic [15:0] addr, input logic [7:0] wd,
                           input int pop_at, output logic [7:0] rd0, output logic [7:0] rd1,
                           output int w0, output int w1);
    int n;
    bit done;
    @(posedge clk); #1;
    a = addr; d = wd;
    m1n   = (kind == 0) ? 1'b0 : 1'b1;
    mreqn = (kind <= 2) ? 1'b0 : 1'b1;
    iorqn = (kind >= 3) ? 1'b0 : 1'b1;
    rdn   = (kind == 0 || kind == 1 || kind == 3) ? 1'b0 : 1'b1;
    wrn   = (kind == 2 || kind == 4) ? 1'b0 : 1'b1;
    if (pop_at == 0) pop1 = 1'b1;
    n = 0; w0 = 0; w1 = 0; done = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      pop1 = 1'b0;
      if (!b0.wait_n) w0++;
      if (!b1.wait_n) w1++;
      if (b0.wait_n && b1.wait_n) done = 1;
      else begin
        n++;
        if (n == pop_at) pop1 = 1'b1;
      end
    end
    if (!done) chk("bus_timeout", 32'd1, 32'd0);
    rd0 = b0.di; rd1 = b1.di;
    m1n = 1; mreqn = 1; iorqn = 1; rdn = 1; wrn = 1; pop1 = 0;
    @(posedge clk); #1;
  endtask

  task automatic log_write(input logic [15:0] addr, input logic [7:0] data, input logic io);
    ent_t e;
    e.a = addr; e.d = data; e.io = io;
    if (exp_q.size() < 4) exp_q.push_back(e);
    else mdl_ovf = 1'b1;
  endtask

  task automatic pop_chk(input string tag);
    ent_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_valid"}, 32'(lv1), 32'd1);
    chk({tag, "_addr"}, 32'(la1), 32'(e.a));
    chk({tag, "_data"}, 32'(ld1), 32'(e.d));
    chk({tag, "_io"}, 32'(lio1), 32'(e.io));
    pop1 = 1'b1;
    @(posedge clk); #1;
    pop1 = 1'b0;
  endtask

  initial begin
    logic [7:0] r0, r1, op, op2, dreg;
    int w0, w1;
    ent_t e;

    rst = 1; a = 16'h0000; d = 8'h00;
    m1n = 1; mreqn = 1; iorqn = 1; rdn = 1; wrn = 1; pop0 = 0; pop1 = 0;
    u_def.mem[16'h0000] = 8'hCB;
    u_def.mem[16'h0001] = 8'hFA;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wait_n", 32'(b1.wait_n), 32'd1);
    chk("rst_count", 32'(lc1), 32'd0);
    chk("rst_valid", 32'(lv1), 32'd0);
    chk("rst_ovf", 32'(ovf1), 32'd0);
    chk("rst_di_cfg", 32'(b1.di), 32'hFF);
    chk("rst_di_def", 32'(b0.di), 32'hFF);
    rst = 0;

    // SET 7,D fetched from the default instance.
    bus_cycle(0, 16'h0000, 8'h00, -1, op, r1, w0, w1);
    chk("fetch_cb", 32'(op), 32'hCB);
    chk("fetch_def_wait", 32'(w0), 32'd0);
    chk("fetch_cfg_wait", 32'(w1), 32'd3);
    bus_cycle(0, 16'h0001, 8'h00, -1, op2, r1, w0, w1);
    chk("fetch_fa", 32'(op2), 32'hFA);
    chk("fetch2_def_wait", 32'(w0), 32'd0);
    dreg = 8'h63;
    if (op == 8'hCB && op2[7:6] == 2'b11 && op2[2:0] == 3'd2) dreg = dreg | (8'h01 << op2[5:3]);
    chk("set7d", 32'(dreg), 32'hE3);
    chk("def_log_empty", 32'(lv0), 32'd0);

    // LD (8000),A
    bus_cycle(2, 16'h8000, 8'h5A, -1, r0, r1, w0, w1);
    chk("memwr_wait", 32'(w1), 32'd3);
    chk("memwr_def_wait", 32'(w0), 32'd0);
    chk("memwr_mem", 32'(u_cfg.mem[16'h8000]), 32'h5A);
    chk("memwr_count", 32'(lc1), 32'd1);
    log_write(16'h8000, 8'h5A, 1'b0);

    // OUT (7F),A: A also drives the upper address byte
    bus_cycle(4, 16'hC37F, 8'hC3, -1, r0, r1, w0, w1);
    chk("iowr_wait", 32'(w1), 32'd2);
    chk("iowr_def_wait", 32'(w0), 32'd1);
    chk("iowr_io", 32'(u_cfg.io[8'h7F]), 32'hC3);
    chk("iowr_count", 32'(lc1), 32'd2);
    log_write(16'h007F, 8'hC3, 1'b1);

    bus_cycle(3, 16'h007F, 8'h00, -1, r0, r1, w0, w1);
    chk("iord_data", 32'(r1), 32'hC3);
    chk("iord_wait", 32'(w1), 32'd2);

    pop_chk("pop_mem");
    pop_chk("pop_io");
    chk("drained_count", 32'(lc1), 32'd0);

    pop1 = 1'b1; @(posedge clk); #1; pop1 = 1'b0;
    chk("pop_empty_count", 32'(lc1), 32'd0);
    chk("pop_empty_valid", 32'(lv1), 32'd0);

    bus_cycle(2, 16'h2000, 8'h11, 3, r0, r1, w0, w1);
    chk("pushpop_empty_count", 32'(lc1), 32'd1);
    log_write(16'h2000, 8'h11, 1'b0);
    pop_chk("pushpop_empty");

    // Overflow: five writes into a four-entry log
    for (int i = 0; i < 5; i++) begin
      bus_cycle(2, 16'h1000 + 16'(i), 8'h20 + 8'(i), -1, r0, r1, w0, w1);
      log_write(16'h1000 + 16'(i), 8'h20 + 8'(i), 1'b0);
    end
    chk("full_count", 32'(lc1), 32'd4);
    chk("full_ovf", 32'(ovf1), 32'(mdl_ovf));
    e = exp_q[0];
    chk("full_head_addr", 32'(la1), 32'(e.a));
    chk("full_head_data", 32'(ld1), 32'(e.d));
    bus_cycle(2, 16'h1100, 8'h99, 3, r0, r1, w0, w1);
    void'(exp_q.pop_front());
    log_write(16'h1100, 8'h99, 1'b0);
    chk("pushpop_full_count", 32'(lc1), 32'd4);
    chk("pushpop_full_ovf", 32'(ovf1), 32'(mdl_ovf));
    for (int i = 0; i < 4; i++) pop_chk($sformatf("drain%0d", i));
    chk("drain_valid", 32'(lv1), 32'd0);

    // Reset in the second wait cycle of a write to FFFF
    u_cfg.mem[16'hFFFF] = 8'hA5;
    @(posedge clk); #1;
    a = 16'hFFFF; d = 8'h77; mreqn = 0; wrn = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_in_wait", 32'(b1.wait_n), 32'd0);
    rst = 1; #1;
    chk("abort_wait_n", 32'(b1.wait_n), 32'd1);
    mreqn = 1; wrn = 1;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("abort_mem", 32'(u_cfg.mem[16'hFFFF]), 32'hA5);
    chk("abort_valid", 32'(lv1), 32'd0);
    chk("abort_count", 32'(lc1), 32'd0);
    chk("abort_ovf", 32'(ovf1), 32'd0);
    mdl_ovf = 1'b0;
    bus_cycle(2, 16'hFFFF, 8'h77, -1, r0, r1, w0, w1);
    chk("after_abort_wait", 32'(w1), 32'd3);
    chk("after_abort_mem", 32'(u_cfg.mem[16'hFFFF]), 32'h77);
    log_write(16'hFFFF, 8'h77, 1'b0);
    pop_chk("after_abort");

    // Interrupt acknowledge and refresh
    u_cfg.io[8'h12]  = 8'h55;
    u_cfg.mem[16'h0012] = 8'h66;
    @(posedge clk); #1;
    a = 16'h0012; m1n = 0; iorqn = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("ack_di%0d", i), 32'(b1.di), 32'hFF);
      chk($sformatf("ack_wait%0d", i), 32'(b1.wait_n), 32'd1);
    end
    m1n = 1; iorqn = 1;
    @(posedge clk); #1;
    mreqn = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rfsh_wait%0d", i), 32'(b1.wait_n), 32'd1);
    end
    mreqn = 1;
    @(posedge clk); #1;
    chk("ack_rfsh_count", 32'(lc1), 32'd0);
    chk("ack_rfsh_valid", 32'(lv1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
